// File: rtl/udp_tx_framer.sv
// rtl/udp_tx_framer.sv - Ethernet II + IPv4 + UDP header framer for a 16-bit payload stream
//
// Store-and-forward framer. The payload is buffered whole, so its byte count is known
// before the 21 header words (42 bytes) are emitted, and the payload words follow them.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_sport/dport/sip/dip    UDP ports and IPv4 addresses, latched at frame start
//   cfg_mac_s/cfg_mac_d        Ethernet addresses, latched at frame start
//   tx_data/vld/sop/eop/mty    payload input; every tx_vld beat is accepted
//   tx_rdy                     source may drive tx_vld in the next cycle only while high
//   dout/vld/sop/eop/mty       frame output, first byte in [15:8]
//   dout_rdy                   sink ready, ready-latency 1
module udp_tx_framer #(
  parameter int DFIFO_DEPTH  = 1024,
  parameter int LFIFO_DEPTH  = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_sport,
  input  logic [15:0] cfg_dport,
  input  logic [31:0] cfg_sip,
  input  logic [31:0] cfg_dip,
  input  logic [47:0] cfg_mac_s,
  input  logic [47:0] cfg_mac_d,
  input  logic [15:0] tx_data,
  input  logic        tx_vld,
  input  logic        tx_sop,
  input  logic        tx_eop,
  input  logic        tx_mty,
  output logic        tx_rdy,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_mty,
  input  logic        dout_rdy
);

  localparam int DAW = $clog2(DFIFO_DEPTH);
  localparam int LAW = $clog2(LFIFO_DEPTH);
  localparam logic [DAW:0]   DCNT_ONE  = 1;
  localparam logic [DAW-1:0] DPTR_ONE  = 1;
  localparam logic [LAW:0]   LCNT_ONE  = 1;
  localparam logic [LAW-1:0] LPTR_ONE  = 1;
  // Free words <= margin is the same as occupancy >= depth - margin.
  localparam logic [DAW:0]   DCNT_LIM  = (DAW+1)'(DFIFO_DEPTH - AFULL_MARGIN);
  localparam logic [LAW:0]   LCNT_FULL = (LAW+1)'(LFIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  // Payload FIFO entry: {eop, mty-at-eop, data}
  logic [17:0]    dmem [DFIFO_DEPTH];
  logic [DAW-1:0] dwr_ptr_q, drd_ptr_q;
  logic [DAW:0]   dcnt_q;
  logic [17:0]    drd_data;
  logic           dpop;

  logic [15:0]    lmem [LFIFO_DEPTH];
  logic [LAW-1:0] lwr_ptr_q, lrd_ptr_q;
  logic [LAW:0]   lcnt_q;
  logic           lpush;

  logic [15:0]    acc_q, acc_now;

  state_t         state_q, state_d;
  logic [4:0]     wcnt_q, wcnt_d;
  logic [15:0]    id_q, len_q;
  logic [47:0]    mac_d_q, mac_s_q;
  logic [31:0]    sip_q, dip_q;
  logic [15:0]    sport_q, dport_q;
  logic           start, frame_done;

  logic [15:0]    tot_len, udp_len, csum, hdr_word;
  logic [31:0]    csum_acc;
  logic [16:0]    csum_f1;
  logic [15:0]    csum_f2;

  logic [15:0]    dout_q, dout_d;
  logic           dout_vld_q, dout_vld_d;
  logic           dout_sop_q, dout_sop_d;
  logic           dout_eop_q, dout_eop_d;
  logic           dout_mty_q, dout_mty_d;

  assign tx_rdy = (dcnt_q < DCNT_LIM) && (lcnt_q != LCNT_FULL);

  // Input side: byte count restarts on sop so a stray partial packet cannot leak into the next.
  assign acc_now = (tx_sop ? 16'd0 : acc_q) + 16'd2 - {15'd0, tx_eop & tx_mty};
  assign lpush   = tx_vld & tx_eop;

  always_ff @(posedge clk) begin
    if (tx_vld) dmem[dwr_ptr_q] <= {tx_eop, tx_eop & tx_mty, tx_data};
    if (lpush)  lmem[lwr_ptr_q] <= acc_now;
  end

  assign drd_data = dmem[drd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwr_ptr_q <= '0;
      drd_ptr_q <= '0;
      dcnt_q    <= '0;
      lwr_ptr_q <= '0;
      lrd_ptr_q <= '0;
      lcnt_q    <= '0;
      acc_q     <= '0;
    end else begin
      if (tx_vld) begin
        dwr_ptr_q <= dwr_ptr_q + DPTR_ONE;
        acc_q     <= tx_eop ? 16'd0 : acc_now;
      end
      if (dpop) drd_ptr_q <= drd_ptr_q + DPTR_ONE;
      if (tx_vld && !dpop)      dcnt_q <= dcnt_q + DCNT_ONE;
      else if (!tx_vld && dpop) dcnt_q <= dcnt_q - DCNT_ONE;
      if (lpush) lwr_ptr_q <= lwr_ptr_q + LPTR_ONE;
      if (start) lrd_ptr_q <= lrd_ptr_q + LPTR_ONE;
      if (lpush && !start)      lcnt_q <= lcnt_q + LCNT_ONE;
      else if (!lpush && start) lcnt_q <= lcnt_q - LCNT_ONE;
    end
  end

  // Header fields derived from the values latched at frame start.
  assign tot_len  = len_q + 16'd28;
  assign udp_len  = len_q + 16'd8;
  assign csum_acc = 32'h4500 + {16'h0, tot_len} + {16'h0, id_q} + 32'h4000 + 32'h4011
                  + {16'h0, sip_q[31:16]} + {16'h0, sip_q[15:0]}
                  + {16'h0, dip_q[31:16]} + {16'h0, dip_q[15:0]};
  // Ten 16-bit terms stay below 2^20, so two folds absorb every carry.
  assign csum_f1  = {1'b0, csum_acc[15:0]} + {1'b0, csum_acc[31:16]};
  assign csum_f2  = csum_f1[15:0] + {15'd0, csum_f1[16]};
  assign csum     = ~csum_f2;

  always_comb begin
    hdr_word = 16'h0000;
    case (wcnt_q)
      5'd0:  hdr_word = mac_d_q[47:32];
      5'd1:  hdr_word = mac_d_q[31:16];
      5'd2:  hdr_word = mac_d_q[15:0];
      5'd3:  hdr_word = mac_s_q[47:32];
      5'd4:  hdr_word = mac_s_q[31:16];
      5'd5:  hdr_word = mac_s_q[15:0];
      5'd6:  hdr_word = 16'h0800;
      5'd7:  hdr_word = 16'h4500;
      5'd8:  hdr_word = tot_len;
      5'd9:  hdr_word = id_q;
      5'd10: hdr_word = 16'h4000;
      5'd11: hdr_word = 16'h4011;
      5'd12: hdr_word = csum;
      5'd13: hdr_word = sip_q[31:16];
      5'd14: hdr_word = sip_q[15:0];
      5'd15: hdr_word = dip_q[31:16];
      5'd16: hdr_word = dip_q[15:0];
      5'd17: hdr_word = sport_q;
      5'd18: hdr_word = dport_q;
      5'd19: hdr_word = udp_len;
      default: hdr_word = 16'h0000;
    endcase
  end

  // Output words are produced on edges where dout_rdy is high, which gives the sink's
  // ready-latency of one. A frame's last word may chain straight into the next header.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    start      = 1'b0;
    frame_done = 1'b0;
    dpop       = 1'b0;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_sop_d = 1'b0;
    dout_eop_d = 1'b0;
    dout_mty_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lcnt_q != '0) begin
          start   = 1'b1;
          wcnt_d  = 5'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (dout_rdy) begin
          dout_d     = hdr_word;
          dout_vld_d = 1'b1;
          dout_sop_d = (wcnt_q == 5'd0);
          if (wcnt_q == 5'd20) state_d = S_PAY;
          else                 wcnt_d  = wcnt_q + 5'd1;
        end
      end
      S_PAY: begin
        if (dout_rdy && dcnt_q != '0) begin
          dpop       = 1'b1;
          dout_d     = drd_data[15:0];
          dout_vld_d = 1'b1;
          if (drd_data[17]) begin
            dout_eop_d = 1'b1;
            dout_mty_d = drd_data[16];
            frame_done = 1'b1;
            if (lcnt_q != '0) begin
              start   = 1'b1;
              wcnt_d  = 5'd0;
              state_d = S_HDR;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      len_q      <= '0;
      mac_d_q    <= '0;
      mac_s_q    <= '0;
      sip_q      <= '0;
      dip_q      <= '0;
      sport_q    <= '0;
      dport_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_mty_q <= 1'b0;
    end else begin
      // The ID increments after the last word, so a chained next frame sees the new value.
      if (frame_done) id_q <= id_q + 16'd1;
      if (start) begin
        len_q   <= lmem[lrd_ptr_q];
        mac_d_q <= cfg_mac_d;
        mac_s_q <= cfg_mac_s;
        sip_q   <= cfg_sip;
        dip_q   <= cfg_dip;
        sport_q <= cfg_sport;
        dport_q <= cfg_dport;
      end
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_sop_q <= dout_sop_d;
      dout_eop_q <= dout_eop_d;
      dout_mty_q <= dout_mty_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_sop = dout_sop_q;
  assign dout_eop = dout_eop_q;
  assign dout_mty = dout_mty_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb/tb_udp_tx_framer.sv - directed table-driven bench for udp_tx_framer
module tb_udp_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_sport, cfg_dport;
  logic [31:0] cfg_sip, cfg_dip;
  logic [47:0] cfg_mac_s, cfg_mac_d;
  logic [15:0] tx_data;
  logic        tx_vld, tx_sop, tx_eop, tx_mty, tx_rdy;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop, dout_mty;
  logic        dout_rdy;

  always #5 clk = ~clk;

  udp_tx_framer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .cfg_sip(cfg_sip), .cfg_dip(cfg_dip),
    .cfg_mac_s(cfg_mac_s), .cfg_mac_d(cfg_mac_d),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mty(tx_mty),
    .tx_rdy(tx_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_mty(dout_mty), .dout_rdy(dout_rdy)
  );

  typedef struct {
    int          n;
    int          words;
    logic        mty;
    logic [15:0] w8, w9, w12, w19, last;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hs_viol = 0;
  int          rdy_mode = 0;   // 0 low, 1 high, 2 random
  int          stall_words = -1;
  logic [18:0] rx_q[$];
  int          rx_t[$];
  logic [18:0] exp_w [0:799];
  logic [18:0] got_w [0:799];
  int          got_first, got_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pb(input int seed, input int i);
    return 8'((seed + i) & 255);
  endfunction

  task automatic build_exp(input int n, input int id, input int seed);
    logic [15:0] h [0:20];
    logic [31:0] s;
    int pw;
    logic last;
    logic [7:0] lo;
    h[0] = cfg_mac_d[47:32]; h[1] = cfg_mac_d[31:16]; h[2] = cfg_mac_d[15:0];
    h[3] = cfg_mac_s[47:32]; h[4] = cfg_mac_s[31:16]; h[5] = cfg_mac_s[15:0];
    h[6] = 16'h0800; h[7] = 16'h4500; h[8] = 16'(28 + n); h[9] = 16'(id);
    h[10] = 16'h4000; h[11] = 16'h4011; h[12] = 16'h0000;
    h[13] = cfg_sip[31:16]; h[14] = cfg_sip[15:0]; h[15] = cfg_dip[31:16]; h[16] = cfg_dip[15:0];
    h[17] = cfg_sport; h[18] = cfg_dport; h[19] = 16'(8 + n); h[20] = 16'h0000;
    s = 0;
    for (int k = 7; k <= 16; k++) s = s + {16'h0, h[k]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    h[12] = ~s[15:0];
    for (int k = 0; k < 21; k++) exp_w[k] = {(k == 0), 1'b0, 1'b0, h[k]};
    pw = (n + 1) / 2;
    for (int p = 0; p < pw; p++) begin
      last = (p == pw - 1);
      lo = (2 * p + 1 < n) ? pb(seed, 2 * p + 1) : 8'h00;
      exp_w[21 + p] = {1'b0, last, last & (n % 2 == 1), pb(seed, 2 * p), lo};
    end
  endtask

  task automatic send_pkt(input int n, input int seed);
    int words, i, waited;
    logic ok;
    words = (n + 1) / 2;
    i = 0;
    waited = 0;
    while (i < words) begin
      @(negedge clk);
      ok = tx_rdy;
      @(posedge clk);
      #1;
      if (ok) begin
        tx_vld  = 1'b1;
        tx_sop  = (i == 0);
        tx_eop  = (i == words - 1);
        tx_mty  = (i == words - 1) && (n % 2 == 1);
        tx_data = {pb(seed, 2 * i), (2 * i + 1 < n) ? pb(seed, 2 * i + 1) : 8'h00};
        i++;
      end else begin
        tx_vld = 1'b0;
        if (stall_words < 0) stall_words = i;
        waited++;
        if (waited > 5000) begin
          chk("send_timeout", 64'(i), 64'(words));
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    tx_vld = 1'b0; tx_sop = 1'b0; tx_eop = 1'b0; tx_mty = 1'b0;
  endtask

  task automatic get_frame(input int n, input int id, input int seed, input string name);
    int words, t, bad, first_bad, tt;
    words = 21 + (n + 1) / 2;
    build_exp(n, id, seed);
    t = 0;
    while (rx_q.size() < words && t < words * 8 + 200) begin
      @(posedge clk);
      t++;
    end
    if (rx_q.size() < words) begin
      chk({name, "_timeout"}, 64'(rx_q.size()), 64'(words));
      return;
    end
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < words; k++) begin
      got_w[k] = rx_q.pop_front();
      tt = rx_t.pop_front();
      if (k == 0) got_first = tt;
      got_last = tt;
      if (got_w[k] !== exp_w[k]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (bad != 0)
      $display("  %s: first bad word %0d got %h want %h", name, first_bad, got_w[first_bad], exp_w[first_bad]);
    chk({name, "_bad_words"}, 64'(bad), 64'd0);
  endtask

  // Output monitor; the ready value seen at each edge is the one the DUT acted on.
  initial begin
    logic rdy_at_edge;
    forever begin
      @(posedge clk);
      rdy_at_edge = dout_rdy;
      cyc++;
      @(negedge clk);
      if (rst_n && dout_vld) begin
        rx_q.push_back({dout_sop, dout_eop, dout_mty, dout});
        rx_t.push_back(cyc);
        if (!rdy_at_edge) hs_viol++;
      end
    end
  end

  initial begin
    dout_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dout_rdy = 1'b0;
        1:       dout_rdy = 1'b1;
        default: dout_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [5];
    int f1_last;
    tab[0] = '{n: 15, words: 29, mty: 1'b1, w8: 16'h002B, w9: 16'h0000, w12: 16'hB75E, w19: 16'h0017, last: 16'h0E00};
    tab[1] = '{n: 16, words: 29, mty: 1'b0, w8: 16'h002C, w9: 16'h0001, w12: 16'hB75C, w19: 16'h0018, last: 16'h0E0F};
    tab[2] = '{n: 17, words: 30, mty: 1'b1, w8: 16'h002D, w9: 16'h0002, w12: 16'hB75A, w19: 16'h0019, last: 16'h1000};
    tab[3] = '{n: 1,  words: 22, mty: 1'b1, w8: 16'h001D, w9: 16'h0003, w12: 16'hB769, w19: 16'h0009, last: 16'h0000};
    tab[4] = '{n: 2,  words: 22, mty: 1'b0, w8: 16'h001E, w9: 16'h0004, w12: 16'hB767, w19: 16'h000A, last: 16'h0001};

    cfg_sport = 16'h1388; cfg_dport = 16'h0bb8;
    cfg_sip = 32'hc0a8010a; cfg_dip = 32'hc0a80109;
    cfg_mac_d = 48'h010203040506; cfg_mac_s = 48'h2c0203040507;
    tx_data = 16'h0; tx_vld = 1'b0; tx_sop = 1'b0; tx_eop = 1'b0; tx_mty = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_vld", 64'(dout_vld), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_sop_eop_mty", 64'({dout_sop, dout_eop, dout_mty}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx_rdy", 64'(tx_rdy), 64'd1);
    chk("post_rst_dout_vld", 64'(dout_vld), 64'd0);

    // Table frames with a random sink
    rdy_mode = 2;
    for (int v = 0; v < 5; v++) begin
      send_pkt(tab[v].n, 0);
      get_frame(tab[v].n, v, 0, $sformatf("v%0d", v));
      chk($sformatf("v%0d_sop_w0", v), 64'(got_w[0][18]), 64'd1);
      chk($sformatf("v%0d_eop_last", v), 64'(got_w[tab[v].words-1][17]), 64'd1);
      chk($sformatf("v%0d_mty", v), 64'(got_w[tab[v].words-1][16]), 64'(tab[v].mty));
      chk($sformatf("v%0d_w8", v), 64'(got_w[8][15:0]), 64'(tab[v].w8));
      chk($sformatf("v%0d_w9", v), 64'(got_w[9][15:0]), 64'(tab[v].w9));
      chk($sformatf("v%0d_w12", v), 64'(got_w[12][15:0]), 64'(tab[v].w12));
      chk($sformatf("v%0d_w19", v), 64'(got_w[19][15:0]), 64'(tab[v].w19));
      chk($sformatf("v%0d_last", v), 64'(got_w[tab[v].words-1][15:0]), 64'(tab[v].last));
    end
    chk("random_rdy_handshake", 64'(hs_viol), 64'd0);

    // Two buffered packets drain back to back
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    send_pkt(5, 8'h20);
    send_pkt(6, 8'h30);
    repeat (5) @(posedge clk);
    rdy_mode = 1;
    get_frame(5, 5, 8'h20, "b2b_a");
    f1_last = got_last;
    get_frame(6, 6, 8'h30, "b2b_b");
    chk("b2b_gap_cycles", 64'(got_first - f1_last), 64'd1);

    // Two maximum payloads against a stalled sink: the second stalls at the margin
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    send_pkt(1472, 8'h11);
    stall_words = -1;
    fork
      send_pkt(1472, 8'h77);
      begin
        int t;
        t = 0;
        while (stall_words < 0 && t < 3000) begin
          @(posedge clk);
          t++;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("big_tx_rdy_low", 64'(tx_rdy), 64'd0);
        chk("big_words_before_stall", 64'(stall_words), 64'd285);
        rdy_mode = 1;
      end
    join
    get_frame(1472, 7, 8'h11, "big_a");
    get_frame(1472, 8, 8'h77, "big_b");
    chk("no_extra_words", 64'(rx_q.size()), 64'd0);
    chk("handshake_total", 64'(hs_viol), 64'd0);

    // Reset in the middle of a frame
    rdy_mode = 1;
    send_pkt(40, 8'h05);
    begin
      int t;
      t = 0;
      while (rx_q.size() < 10 && t < 500) begin
        @(posedge clk);
        t++;
      end
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout_vld", 64'(dout_vld), 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_sop_eop_mty", 64'({dout_sop, dout_eop, dout_mty}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_q.delete();
    rx_t.delete();
    send_pkt(15, 0);
    get_frame(15, 0, 0, "post_reset");
    chk("post_reset_w9", 64'(got_w[9][15:0]), 64'h0000);
    chk("post_reset_w12", 64'(got_w[12][15:0]), 64'hB75E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
